// File: rtl/xfer_sequencer.sv
// Sequences RAM<->accelerator transfers for one FFT/FIR/IIR job at a time.
// Latency: start -> ARM next edge; RUN grants (pauses, strobes) follow inputs in the same cycle.
// Backpressure: with neither direction grantable RUN holds; the optional watchdog bounds the stall.
module xfer_sequencer #(
    parameter int WDOG_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic [WDOG_W-1:0] wdog_limit,
    input  logic              acc_in_ready,
    input  logic              acc_out_valid,
    input  logic              fft_read_done,
    input  logic              fft_write_done,
    input  logic              fir_read_done,
    input  logic              fir_write_done,
    input  logic              iir_read_done,
    input  logic              iir_write_done,
    output logic              fft_enable,
    output logic              fir_enable,
    output logic              iir_enable,
    output logic              fft_read_pause,
    output logic              fft_write_pause,
    output logic              fir_read_pause,
    output logic              fir_write_pause,
    output logic              iir_read_pause,
    output logic              iir_write_pause,
    output logic              ram_re,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FFT = 2'b01;
    localparam logic [1:0] MODE_FIR = 2'b10;
    localparam logic [1:0] MODE_IIR = 2'b11;

    localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [1:0]        mode_q;
    logic              rd_seen_q;
    logic              wr_seen_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [2:0]        en_q;      // {fft, fir, iir}
    logic              done_q;
    logic              err_q;

    logic              in_run;
    logic              wr_grant;
    logic              rd_grant;
    logic              hold;
    logic              sel_rd_done;
    logic              sel_wr_done;
    logic              rd_seen_d;
    logic              wr_seen_d;
    logic [WDOG_W-1:0] wdog_d;
    logic              wdog_trip;

    // One-hot enable pattern for a legal mode
    function automatic logic [2:0] mode_onehot(input logic [1:0] m);
        logic [2:0] oh;
        oh = 3'b000;
        case (m)
            MODE_FFT: oh = 3'b100;
            MODE_FIR: oh = 3'b010;
            MODE_IIR: oh = 3'b001;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Route the latched accelerator's completion flags
    always_comb begin
        sel_rd_done = 1'b0;
        sel_wr_done = 1'b0;
        case (mode_q)
            MODE_FFT: begin
                sel_rd_done = fft_read_done;
                sel_wr_done = fft_write_done;
            end
            MODE_FIR: begin
                sel_rd_done = fir_read_done;
                sel_wr_done = fir_write_done;
            end
            MODE_IIR: begin
                sel_rd_done = iir_read_done;
                sel_wr_done = iir_write_done;
            end
            default: begin
                sel_rd_done = 1'b0;
                sel_wr_done = 1'b0;
            end
        endcase
    end

    // Direction arbitration is combinational on the accelerator handshakes so the
    // strobe lands in the same cycle the word is offered; write drains first.
    assign in_run   = (state_q == S_RUN);
    assign wr_grant = in_run && acc_out_valid && !wr_seen_q;
    assign rd_grant = in_run && !wr_grant && acc_in_ready && !rd_seen_q;
    assign hold     = in_run && !wr_grant && !rd_grant;

    // Next values of the sticky completion flags and the saturating stall counter
    always_comb begin
        rd_seen_d = rd_seen_q | (in_run & sel_rd_done);
        wr_seen_d = wr_seen_q | (in_run & sel_wr_done);
        wdog_d    = wdog_q;
        if (rd_grant || wr_grant) begin
            wdog_d = '0;
        end else if (hold && (wdog_q != '1)) begin
            wdog_d = wdog_q + WDOG_ONE;
        end
        wdog_trip = (wdog_limit != '0) && (wdog_d >= wdog_limit);
    end

    // Job FSM with registered enables, done pulse and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b00;
            rd_seen_q <= 1'b0;
            wr_seen_q <= 1'b0;
            wdog_q    <= '0;
            en_q      <= 3'b000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (mode != 2'b00) begin
                            mode_q    <= mode;
                            rd_seen_q <= 1'b0;
                            wr_seen_q <= 1'b0;
                            wdog_q    <= '0;
                            err_q     <= 1'b0;
                            en_q      <= mode_onehot(mode);
                            state_q   <= S_ARM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        en_q    <= 3'b000;
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    rd_seen_q <= rd_seen_d;
                    wr_seen_q <= wr_seen_d;
                    wdog_q    <= wdog_d;
                    // Abort outranks a completion landing in the same cycle
                    if (abort) begin
                        en_q    <= 3'b000;
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else if (rd_seen_d && wr_seen_d) begin
                        en_q    <= 3'b000;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (wdog_trip) begin
                        en_q    <= 3'b000;
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    en_q    <= 3'b000;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fft_enable = en_q[2];
    assign fir_enable = en_q[1];
    assign iir_enable = en_q[0];

    // A pause drops only for the granted direction of the latched accelerator
    assign fft_read_pause  = !(rd_grant && (mode_q == MODE_FFT));
    assign fft_write_pause = !(wr_grant && (mode_q == MODE_FFT));
    assign fir_read_pause  = !(rd_grant && (mode_q == MODE_FIR));
    assign fir_write_pause = !(wr_grant && (mode_q == MODE_FIR));
    assign iir_read_pause  = !(rd_grant && (mode_q == MODE_IIR));
    assign iir_write_pause = !(wr_grant && (mode_q == MODE_IIR));

    assign ram_re = rd_grant;
    assign ram_we = wr_grant;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Directed bench for xfer_sequencer: one task per scenario, inline compares.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// No DUT-event waits; every scenario runs a fixed number of cycles.
module tb_xfer_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        abort;
    logic [15:0] wdog_limit;
    logic        acc_in_ready, acc_out_valid;
    logic        fft_read_done, fft_write_done;
    logic        fir_read_done, fir_write_done;
    logic        iir_read_done, iir_write_done;
    logic        fft_enable, fir_enable, iir_enable;
    logic        fft_read_pause, fft_write_pause;
    logic        fir_read_pause, fir_write_pause;
    logic        iir_read_pause, iir_write_pause;
    logic        ram_re, ram_we, busy, done, err;

    logic [2:0]  ev;
    logic [5:0]  pv;
    logic [4:0]  sv;

    int checks = 0;
    int passed = 0;
    int re_cnt, we_cnt, done_cnt, both_cnt;

    assign ev = {fft_enable, fir_enable, iir_enable};
    assign pv = {fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause,
                 iir_read_pause, iir_write_pause};
    assign sv = {ram_re, ram_we, busy, done, err};

    xfer_sequencer #(.WDOG_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .wdog_limit(wdog_limit), .acc_in_ready(acc_in_ready), .acc_out_valid(acc_out_valid),
        .fft_read_done(fft_read_done), .fft_write_done(fft_write_done),
        .fir_read_done(fir_read_done), .fir_write_done(fir_write_done),
        .iir_read_done(iir_read_done), .iir_write_done(iir_write_done),
        .fft_enable(fft_enable), .fir_enable(fir_enable), .iir_enable(iir_enable),
        .fft_read_pause(fft_read_pause), .fft_write_pause(fft_write_pause),
        .fir_read_pause(fir_read_pause), .fir_write_pause(fir_write_pause),
        .iir_read_pause(iir_read_pause), .iir_write_pause(iir_write_pause),
        .ram_re(ram_re), .ram_we(ram_we), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_inputs();
        start = 0; mode = 2'b00; abort = 0;
        acc_in_ready = 0; acc_out_valid = 0;
        fft_read_done = 0; fft_write_done = 0;
        fir_read_done = 0; fir_write_done = 0;
        iir_read_done = 0; iir_write_done = 0;
    endtask

    task automatic test_reset();
        // Reset held together with a legal start: reset must win
        reset = 1; clr_inputs(); start = 1; mode = 2'b01; wdog_limit = 16'd0;
        @(negedge clk); #1;
        checks++; if (ev !== 3'b000) $display("FAIL reset_en: got %b want 000", ev); else passed++;
        checks++; if (pv !== 6'b111111) $display("FAIL reset_pause: got %b want 111111", pv); else passed++;
        checks++; if (sv !== 5'b00000) $display("FAIL reset_status: got %b want 00000", sv); else passed++;
        @(negedge clk); reset = 0; clr_inputs(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b want 0", busy); else passed++;
    endtask

    task automatic test_fir_job();
        @(negedge clk); clr_inputs(); start = 1; mode = 2'b10;
        @(negedge clk); clr_inputs(); #1;
        checks++; if (ev !== 3'b010) $display("FAIL fir_arm_en: got %b want 010", ev); else passed++;
        checks++; if (pv !== 6'b111111) $display("FAIL fir_arm_pause: got %b want 111111", pv); else passed++;
        checks++; if (sv !== 5'b00100) $display("FAIL fir_arm_status: got %b want 00100", sv); else passed++;
        re_cnt = 0; we_cnt = 0; done_cnt = 0; both_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc_in_ready   = (c < 4);
            fir_read_done  = (c == 4);
            acc_out_valid  = (c >= 5 && c < 9);
            fir_write_done = (c == 9);
            #1;
            re_cnt += int'(ram_re); we_cnt += int'(ram_we); done_cnt += int'(done);
            if (ram_re && ram_we) both_cnt++;
            if (c == 0) begin
                checks++; if (pv !== 6'b110111) $display("FAIL fir_read_pause: got %b want 110111", pv); else passed++;
            end
            if (c == 5) begin
                checks++; if (pv !== 6'b111011) $display("FAIL fir_write_pause: got %b want 111011", pv); else passed++;
            end
            if (c == 10) begin
                checks++; if ({ev, done, busy} !== 5'b00011) $display("FAIL fir_finish: got %b want 00011", {ev, done, busy}); else passed++;
            end
            if (c == 11) begin
                checks++; if ({fir_enable, busy, done} !== 3'b000) $display("FAIL fir_idle: got %b want 000", {fir_enable, busy, done}); else passed++;
            end
        end
        clr_inputs();
        checks++; if (re_cnt !== 4) $display("FAIL fir_re_count: got %0d want 4", re_cnt); else passed++;
        checks++; if (we_cnt !== 4) $display("FAIL fir_we_count: got %0d want 4", we_cnt); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL fir_done_count: got %0d want 1", done_cnt); else passed++;
        checks++; if (both_cnt !== 0) $display("FAIL fir_both_strobes: got %0d want 0", both_cnt); else passed++;
    endtask

    task automatic test_write_priority();
        @(negedge clk); clr_inputs(); start = 1; mode = 2'b01;
        @(negedge clk); clr_inputs();                       // ARM
        @(negedge clk); acc_in_ready = 1; acc_out_valid = 1; #1;
        checks++; if ({fft_read_pause, fft_write_pause, ram_re, ram_we} !== 4'b1001)
            $display("FAIL fft_wr_priority: got %b want 1001", {fft_read_pause, fft_write_pause, ram_re, ram_we}); else passed++;
        checks++; if ({ev, pv[3:0]} !== 7'b1001111) $display("FAIL fft_others_idle: got %b want 1001111", {ev, pv[3:0]}); else passed++;
        @(negedge clk); clr_inputs(); fft_write_done = 1;
        // Write side finished: the same handshake pair now grants a read
        @(negedge clk); clr_inputs(); acc_in_ready = 1; acc_out_valid = 1; #1;
        checks++; if ({fft_read_pause, fft_write_pause, ram_re, ram_we} !== 4'b0110)
            $display("FAIL fft_after_wr_seen: got %b want 0110", {fft_read_pause, fft_write_pause, ram_re, ram_we}); else passed++;
        @(negedge clk); clr_inputs(); fft_read_done = 1;
        @(negedge clk); clr_inputs(); #1;
        checks++; if ({done, fft_enable} !== 2'b10) $display("FAIL fft_finish: got %b want 10", {done, fft_enable}); else passed++;
        @(negedge clk); #1;
    endtask

    task automatic test_watchdog();
        wdog_limit = 16'd3;
        done_cnt = 0;
        @(negedge clk); clr_inputs(); start = 1; mode = 2'b10;
        @(negedge clk); clr_inputs();                       // ARM
        for (int h = 1; h <= 3; h++) begin
            @(negedge clk); #1;                             // hold cycle h
            done_cnt += int'(done);
            if (h == 3) begin
                checks++; if ({busy, err} !== 2'b10) $display("FAIL wdog_hold3: got %b want 10", {busy, err}); else passed++;
            end
        end
        @(negedge clk); #1;
        done_cnt += int'(done);
        checks++; if ({ev, pv, ram_re, ram_we, err} !== 12'b000_111111_001)
            $display("FAIL wdog_error: got %b want 000111111001", {ev, pv, ram_re, ram_we, err}); else passed++;
        @(negedge clk); #1;
        done_cnt += int'(done);
        checks++; if ({busy, err} !== 2'b01) $display("FAIL wdog_sticky: got %b want 01", {busy, err}); else passed++;
        checks++; if (done_cnt !== 0) $display("FAIL wdog_no_done: got %0d want 0", done_cnt); else passed++;
        wdog_limit = 16'd0;
    endtask

    task automatic test_abort_vs_done();
        @(negedge clk); clr_inputs(); start = 1; mode = 2'b11;
        @(negedge clk); clr_inputs(); #1;
        checks++; if ({ev, err} !== 4'b0010) $display("FAIL iir_arm_errclr: got %b want 0010", {ev, err}); else passed++;
        @(negedge clk); iir_read_done = 1;
        @(negedge clk); clr_inputs(); abort = 1; iir_write_done = 1;
        @(negedge clk); clr_inputs(); #1;
        checks++; if ({ev, done, err} !== 5'b00001) $display("FAIL abort_wins: got %b want 00001", {ev, done, err}); else passed++;
        @(negedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL abort_idle: got %b want 00", {busy, done}); else passed++;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk); clr_inputs(); start = 1; mode = 2'b10;
        @(negedge clk); clr_inputs();                       // ARM
        @(negedge clk); acc_in_ready = 1; #1;
        checks++; if (ram_re !== 1'b1) $display("FAIL mid_run_re: got %b want 1", ram_re); else passed++;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; clr_inputs(); start = 1; mode = 2'b01; #1;
        checks++; if ({ev, pv, sv} !== 14'b000_111111_00000)
            $display("FAIL mid_run_reset: got %b want 00011111100000", {ev, pv, sv}); else passed++;
        @(negedge clk); clr_inputs(); abort = 1; #1;
        checks++; if ({ev, busy} !== 4'b1001) $display("FAIL restart_arm: got %b want 1001", {ev, busy}); else passed++;
        @(negedge clk); clr_inputs(); #1;
        checks++; if ({ev, err, busy} !== 5'b00011) $display("FAIL arm_abort: got %b want 00011", {ev, err, busy}); else passed++;
        @(negedge clk); #1;
    endtask

    task automatic test_start_rules();
        @(negedge clk); clr_inputs(); reset = 1;
        @(negedge clk); reset = 0; start = 1; mode = 2'b00; #1;
        checks++; if (err !== 1'b0) $display("FAIL rules_err_pre: got %b want 0", err); else passed++;
        @(negedge clk); start = 1; mode = 2'b10; #1;
        checks++; if ({busy, err} !== 2'b01) $display("FAIL illegal_mode: got %b want 01", {busy, err}); else passed++;
        @(negedge clk); start = 1; mode = 2'b01; #1;
        checks++; if ({ev, busy, err} !== 5'b01010) $display("FAIL legal_after_err: got %b want 01010", {ev, busy, err}); else passed++;
        @(negedge clk); start = 1; mode = 2'b00; #1;
        checks++; if ({ev, busy, err} !== 5'b01010) $display("FAIL busy_start1: got %b want 01010", {ev, busy, err}); else passed++;
        @(negedge clk); clr_inputs(); abort = 1; #1;
        checks++; if ({ev, busy, err} !== 5'b01010) $display("FAIL busy_start2: got %b want 01010", {ev, busy, err}); else passed++;
        @(negedge clk); clr_inputs();
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) $display("FAIL rules_end_idle: got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_fir_job();
        test_write_priority();
        test_watchdog();
        test_abort_vs_done();
        test_reset_mid_run();
        test_start_rules();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/xfer_sequencer.md
XFER_SEQUENCER -- requirements
Module: xfer_sequencer

Interface
REQ-001 SHALL have parameter WDOG_W, default 16, width of the idle watchdog counter.
REQ-002 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-005 mode  in  2  target accelerator, latched on accepted start: 01 FFT, 10 FIR, 11 IIR, 00 illegal.
REQ-006 abort  in  1  terminate the current job.
REQ-007 wdog_limit  in  WDOG_W  maximum stall cycles; 0 disables the watchdog.
REQ-008 acc_in_ready  in  1  selected accelerator can accept a RAM->accelerator word.
REQ-009 acc_out_valid  in  1  selected accelerator holds an accelerator->RAM word.
REQ-010 fft_read_done, fft_write_done, fir_read_done, fir_write_done, iir_read_done, iir_write_done  in  1 each  address-calculator completion flags.
REQ-011 fft_enable, fir_enable, iir_enable  out  1 each  address-calculator enables; at most one high (one-hot or zero).
REQ-012 fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause, iir_read_pause, iir_write_pause  out  1 each  per-direction pause; 1 = hold.
REQ-013 ram_re, ram_we  out  1 each  RAM read / write strobe for the current cycle.
REQ-014 busy  out  1  job in progress (any state other than IDLE).
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 err  out  1  sticky error flag; cleared by the next accepted start or by reset.

Function
REQ-017 SHALL implement the states IDLE, ARM, RUN, FINISH, ERROR.
REQ-018 IDLE: start=1 with mode!=00 -> latch mode, clear rd_seen/wr_seen/watchdog, go to ARM; start with mode=00 -> set err, stay IDLE.
REQ-019 ARM (exactly 1 cycle): selected enable=1, both of its pauses=1, no strobes; next state RUN.
REQ-020 RUN: selected enable held at 1; per cycle the direction pair {read_pause,write_pause} SHALL be 10 (write), 01 (read) or 11 (hold), never 00.
REQ-021 RUN arbitration priority: acc_out_valid && !wr_seen -> write (ram_we=1); else acc_in_ready && !rd_seen -> read (ram_re=1); else hold.
REQ-022 rd_seen / wr_seen SHALL be sticky: set when the selected read_done / write_done is sampled 1; direction no longer granted afterwards.
REQ-023 RUN -> FINISH in the cycle after both rd_seen and wr_seen are set; FINISH drives done=1 and all enables=0 for 1 cycle, then IDLE.
REQ-024 Pause/enable outputs of non-selected accelerators SHALL stay 1 / 0 throughout the job.
REQ-025 Watchdog: counter increments each RUN hold cycle, clears on any read or write grant; reaching wdog_limit (limit!=0) -> ERROR.
REQ-026 Watchdog counter SHALL saturate and never wrap.
REQ-027 abort in ARM or RUN -> ERROR on the next edge; abort takes priority over completion in the same cycle.
REQ-028 ERROR (1 cycle): err=1, all enables 0, all pauses 1, no strobes, then IDLE; no done pulse.
REQ-029 start while busy SHALL be ignored with no effect on state or err.
REQ-030 ram_re and ram_we SHALL never both be 1; strobes SHALL only assert in RUN.

Reset
REQ-031 reset=1 at any edge, including mid-job: state IDLE, enables 0, all pauses 1, ram_re/ram_we/busy/done/err 0, counters and seen flags 0.
REQ-032 reset SHALL take priority over start and abort in the same cycle.

Verification
REQ-033 Cover FIR job: start, mode=10; acc_in_ready=1 for 4 cycles, then fir_read_done; acc_out_valid for 4 cycles, then fir_write_done -> ARM 1 cycle, 4 ram_re, 4 ram_we, done pulse once, fir_enable low after FINISH.
REQ-034 Cover simultaneous acc_in_ready=1 and acc_out_valid=1 (FFT mode) -> write granted: fft_read_pause=1, fft_write_pause=0, ram_we=1.
REQ-035 Cover wdog_limit=3, RUN with both inputs low -> ERROR on the 3rd hold cycle, err=1 sticky, no done pulse.
REQ-036 Cover abort and final iir_write_done in the same cycle -> ERROR, no done pulse.
REQ-037 Cover reset asserted mid-RUN -> all outputs at reset values on the next edge; new start accepted immediately afterwards.
REQ-038 Cover start with mode=00 -> err=1, busy stays 0; start while busy -> ignored.
